// File: rtl/regfile_pkg.sv
// Shared types, constants and reset preload helper for the LEGv8 register file.
// Optional write-through bypass is controlled by the REGFILE_BYPASS_EN macro (see regfile_rdport).
package regfile_pkg;

  localparam int N     = 64;
  localparam int NREGS = 32;

  typedef logic [4:0]   reg_idx_t;
  typedef logic [N-1:0] word_t;

  localparam reg_idx_t XZR = 5'd31;

  // Program-test preload: register i powers up holding the value i.
  function automatic word_t reset_value(input int unsigned i);
    return word_t'(i);
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: XZR decode plus, under REGFILE_BYPASS_EN, a
// write-through mux that forwards the in-flight write data to a matching read.
module regfile_rdport #(
  parameter int N = 64
) (
  input  logic [4:0]   ra,
  input  logic [N-1:0] stored,
  input  logic         reset,
  input  logic         we,
  input  logic [4:0]   wa,
  input  logic [N-1:0] wd,
  output logic [N-1:0] rd
);
  import regfile_pkg::*;

  reg_idx_t ra_idx;
  logic     is_xzr;

  assign ra_idx = ra;
  assign is_xzr = (ra_idx == XZR);

`ifdef REGFILE_BYPASS_EN
  logic bypass_hit;

  // Writes to XZR never forward, so reads of X31 stay zero.
  assign bypass_hit = we && !reset && (wa != XZR) && (ra_idx == wa);

  always_comb begin
    rd = stored;
    if (is_xzr) begin
      rd = '0;
    end else if (bypass_hit) begin
      rd = wd;
    end
  end
`else
  logic unused_bypass_inputs;

  assign unused_bypass_inputs = &{1'b0, reset, we, wa, wd};

  always_comb begin
    rd = stored;
    if (is_xzr) begin
      rd = '0;
    end
  end
`endif

endmodule

// File: rtl/regfile.sv
// 32-entry LEGv8 register file: two combinational read ports, one synchronous write port.
// Define REGFILE_BYPASS_EN for same-cycle write-through on the read ports.
module regfile #(
  parameter int N     = 64,
  parameter int NREGS = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [4:0]   ra1,
  input  logic [4:0]   ra2,
  output logic [N-1:0] rd1,
  output logic [N-1:0] rd2,
  input  logic         we3,
  input  logic [4:0]   wa3,
  input  logic [N-1:0] wd3
);
  import regfile_pkg::*;

  localparam int NSTORE = NREGS - 1;

  logic [N-1:0] regs_q [NSTORE];
  logic [N-1:0] regs_d [NSTORE];
  logic [N-1:0] stored1;
  logic [N-1:0] stored2;
  reg_idx_t     wa_idx;

  assign wa_idx = wa3;

  // An X or Z on we3 fails the if-test, so a disabled write can never load X.
  always_comb begin
    regs_d = regs_q;
    if (we3 == 1'b1 && wa_idx != XZR && 32'(wa_idx) < NSTORE) begin
      regs_d[wa_idx] = wd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSTORE; i++) begin
        regs_q[i] <= N'(reset_value(i));
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    stored1 = '0;
    stored2 = '0;
    if (32'(ra1) < NSTORE) begin
      stored1 = regs_q[ra1];
    end
    if (32'(ra2) < NSTORE) begin
      stored2 = regs_q[ra2];
    end
  end

  regfile_rdport #(.N(N)) u_rdport1 (
    .ra     (ra1),
    .stored (stored1),
    .reset  (reset),
    .we     (we3),
    .wa     (wa3),
    .wd     (wd3),
    .rd     (rd1)
  );

  regfile_rdport #(.N(N)) u_rdport2 (
    .ra     (ra2),
    .stored (stored2),
    .reset  (reset),
    .we     (we3),
    .wa     (wa3),
    .wd     (wd3),
    .rd     (rd2)
  );

endmodule

// File: doc/regfile.md
# regfile

64-bit, 32-entry LEGv8 integer register file with two combinational read ports and one synchronous write port. It sits directly upstream of `alu`: `rd1` drives the ALU `a` operand and `rd2` drives the `b` operand, either directly or through the immediate mux. The write-back path (ALU result or memory data) returns through port 3. X31 (XZR) always reads as zero and ignores writes.

## Interface
- `N`, default 64: data width in bits.
- `NREGS`, default 32: number of architectural registers. The index field is fixed at 5 bits.
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `ra1`, in, 5: read address for port 1.
- `ra2`, in, 5: read address for port 2.
- `rd1`, out, N: read data for port 1.
- `rd2`, out, N: read data for port 2.
- `we3`, in, 1: write enable for port 3.
- `wa3`, in, 5: write address for port 3.
- `wd3`, in, N: write data for port 3.

## Operation
- Storage: X0..X30, N bits each. X31 has no storage and reads constant zero.
- Reset (asynchronous assert, any time):
  - Each Xi is set to the value i (X0=0, X1=1, … X30=30, i.e. X30 = 64'h1e).
  - This preload is the standard program-test initial state.
  - While `reset` is high, writes are blocked.
- Write:
  - On posedge `clk` with `reset` low, `we3`=1 and `wa3`≠31: X[wa3] ← wd3.
  - `wa3`=31 is silently discarded.
  - `we3`=0: no state change.
- Read:
  - Combinational. `rdK` = 0 if `raK`=31, otherwise X[raK].
  - Both ports are independent and may address the same register.
- Arithmetic: none. Values are stored and returned bit-exact, with no sign extension.
- X/Z on `we3` is treated as no-write. Registers must never take X from a disabled write.

## Timing
- Read latency: 0 cycles (combinational from `raK` and storage to `rdK`).
- Write latency: 1 edge. Data written at edge k is visible on `rdK` after edge k, in the same cycle.
- Same-cycle read/write of the same register (without bypass): `rdK` returns the old value until the edge, then the new one.
- Reset outputs: `rd1`/`rd2` reflect the preload immediately (e.g. `ra1`=5 gives 5) without waiting for a clock edge.
- Reset deassertion coincident with a write edge: the write is dropped. The first write is taken on the first edge with `reset` sampled low.
- Reset asserted mid-sequence: all pending state is lost and the preload values are restored asynchronously.

## Configuration
- Macro `REGFILE_BYPASS_EN`.
- Defined: when `we3`=1, `reset` low, `wa3`≠31 and `raK`=`wa3`, then `rdK`=`wd3` combinationally. This is write-through for the pipelined datapath (WB→ID in the same cycle).
- Defined, `wa3`=31: no bypass; reads of 31 stay 0.
- Not defined: pure storage read, as in the Timing section. This is the single-cycle datapath configuration.

## Structure
- Package `regfile_pkg`:
  - `N`, `NREGS`.
  - `XZR` = 5'd31.
  - `reg_idx_t` (logic [4:0]) and `word_t` (logic [N-1:0]).
  - Function `reset_value(i)` returning i zero-extended to N bits.
- Sub-module `regfile_rdport`:
  - One read port: zero-register decode plus the optional bypass mux.
  - Instantiated twice.
  - All `REGFILE_BYPASS_EN` logic lives here.

## Test plan
1. Reset, then read all addresses: `ra1`=0..30 returns 0..30, `ra1`=31 returns 0. Repeat on `ra2`.
2. Write X9 ← 64'hf000000000000000 (`we3`=1); next cycle `ra1`=`ra2`=9 both return 64'hf000000000000000. With `we3`=0 and `wd3`=64'h1 on the next edge, X9 is unchanged.
3. Write `wa3`=31, `wd3`=64'hdeadbeef, then `ra1`=31 returns 0. Check all other registers are unchanged.
4. Same-cycle hazard: `we3`=1, `wa3`=2, `wd3`=64'h7000000000000001, `ra1`=2 before the edge.
   - Bypass off: returns 2.
   - Bypass on: returns 64'h7000000000000001.
   - After the edge, both configurations return 64'h7000000000000001.
5. Write X4 ← 64'hb, then pulse `reset` between clock edges: `rd1`(`ra1`=4) returns 4 immediately, asynchronously. A write edge with `reset` high is ignored.
6. Drive `rd1`/`rd2` into `alu` with ALUControl 4'd6, `ra1`=10, `ra2`=1: result 64'h9, zero=0. With `ra1`=`ra2`=31: result 0, zero=1.
